// File: rtl/stream_cipher_pkg.sv
// ============================================================
// stream_cipher_pkg : shared byte type and AES forward S-box
// Rev 1.0
// ============================================================
`default_nettype none

package stream_cipher_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

`default_nettype wire

// File: rtl/stream_cipher_if.sv
// ============================================================
// stream_cipher_if : key load, byte input and byte output bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface stream_cipher_if;
   import stream_cipher_pkg::*;

   logic  key_in;
   byte_t key;
   byte_t ptxt_char;
   logic  din_valid;
   byte_t ctxt_char;
   logic  dout_valid;

   modport master (
      output key_in, key, ptxt_char, din_valid,
      input  ctxt_char, dout_valid
   );

   modport slave (
      input  key_in, key, ptxt_char, din_valid,
      output ctxt_char, dout_valid
   );
endinterface

`default_nettype wire

// File: rtl/stream_cipher_sbox.sv
// ============================================================
// stream_cipher_sbox : combinational AES forward S-box lookup
// Rev 1.0
// ============================================================
`default_nettype none

module stream_cipher_sbox
   import stream_cipher_pkg::*;
(
   input  byte_t addr,
   output byte_t data
);

   assign data = SBOX[addr];

endmodule

`default_nettype wire

// File: rtl/stream_cipher.sv
// ============================================================
// stream_cipher : byte-serial XOR cipher, keystream SBOX[key+idx]
// Rev 1.0
// ============================================================
`default_nettype none

module stream_cipher
   import stream_cipher_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   stream_cipher_if.slave bus
);

   byte_t key_q, key_d;
   byte_t idx_q, idx_d;
   byte_t ctxt_q, ctxt_d;
   logic  valid_q, valid_d;
   byte_t ks_addr;
   byte_t ks_byte;

   // 8-bit sum wraps naturally, giving the 256-byte keystream period
   assign ks_addr = key_q + idx_q;

   stream_cipher_sbox u_sbox (
      .addr (ks_addr),
      .data (ks_byte)
   );

   always_comb begin
      key_d   = key_q;
      idx_d   = idx_q;
      ctxt_d  = ctxt_q;
      valid_d = 1'b0;
      if (bus.key_in) begin
         // a byte offered alongside a key load is dropped
         key_d = bus.key;
         idx_d = '0;
      end else if (bus.din_valid) begin
         ctxt_d  = bus.ptxt_char ^ ks_byte;
         valid_d = 1'b1;
         idx_d   = idx_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         idx_q   <= '0;
         ctxt_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         key_q   <= key_d;
         idx_q   <= idx_d;
         ctxt_q  <= ctxt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.ctxt_char  = ctxt_q;
   assign bus.dout_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_cipher.sv
// ============================================================
// tb_stream_cipher : randomized and directed checks against a GF(2^8) model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_stream_cipher;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stream_cipher_if bus ();

   stream_cipher dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] sb [256];
   logic [7:0] m_key = 8'h00;
   logic [7:0] m_idx = 8'h00;
   logic [7:0] m_ct  = 8'h00;
   logic       m_v   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] w;
      w = {x, x} << n;
      return w[15:8];
   endfunction

   // S-box built from its definition: multiplicative inverse then affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   // Reference model and per-cycle compare
   initial begin
      logic [7:0] a;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_key = 8'h00; m_idx = 8'h00; m_ct = 8'h00; m_v = 1'b0;
         end else if (bus.key_in) begin
            m_key = bus.key; m_idx = 8'h00; m_v = 1'b0;
         end else if (bus.din_valid) begin
            a     = m_key + m_idx;
            m_ct  = bus.ptxt_char ^ sb[a];
            m_v   = 1'b1;
            m_idx = m_idx + 8'd1;
         end else begin
            m_v = 1'b0;
         end
         #1;
         check("cyc_ctxt", {24'h0, bus.ctxt_char}, {24'h0, m_ct});
         check("cyc_valid", {31'h0, bus.dout_valid}, {31'h0, m_v});
      end
   end

   task automatic drive(input logic k_in, input logic [7:0] k, input logic v, input logic [7:0] p);
      @(negedge clk);
      bus.key_in = k_in; bus.key = k; bus.din_valid = v; bus.ptxt_char = p;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   logic [7:0] orig [16];
   logic [7:0] ct   [16];

   initial begin
      rst_n = 1'b0;
      bus.key_in = 1'b0; bus.key = 8'h00; bus.din_valid = 1'b0; bus.ptxt_char = 8'h00;
      build_sbox();
      check("sbox_00", {24'h0, sb[0]},   32'h63);
      check("sbox_41", {24'h0, sb[65]},  32'h83);
      check("sbox_42", {24'h0, sb[66]},  32'h2c);
      check("sbox_ff", {24'h0, sb[255]}, 32'h16);

      repeat (2) @(negedge clk);
      check("rst_ctxt",  {24'h0, bus.ctxt_char},  32'h0);
      check("rst_valid", {31'h0, bus.dout_valid}, 32'h0);
      rst_n = 1'b1;

      // key 0, 65536 bytes back-to-back
      drive(1'b1, 8'h00, 1'b0, 8'h00);
      for (int b = 0; b < 65536; b++) begin
         drive(1'b0, 8'h00, 1'b1, 8'(b));
         if (b == 0) begin
            after_edge();
            check("first_out", {24'h0, bus.ctxt_char}, 32'h63);
         end
      end
      drive(1'b0, 8'h00, 1'b0, 8'h00);

      // key 0x41
      drive(1'b1, 8'h41, 1'b0, 8'h00);
      drive(1'b0, 8'h00, 1'b1, 8'h41); after_edge();
      check("k41_b0", {24'h0, bus.ctxt_char}, 32'hc2);
      drive(1'b0, 8'h00, 1'b1, 8'h41); after_edge();
      check("k41_b1", {24'h0, bus.ctxt_char}, 32'h6d);

      // key 0xFF wraps address
      drive(1'b1, 8'hff, 1'b0, 8'h00);
      drive(1'b0, 8'h00, 1'b1, 8'h00); after_edge();
      check("kff_b0", {24'h0, bus.ctxt_char}, 32'h16);
      drive(1'b0, 8'h00, 1'b1, 8'h00); after_edge();
      check("kff_b1", {24'h0, bus.ctxt_char}, 32'h63);

      // one byte every other cycle, then decrypt
      drive(1'b1, 8'h41, 1'b0, 8'h00);
      for (int i = 0; i < 16; i++) begin
         orig[i] = 8'($urandom);
         drive(1'b0, 8'h00, 1'b1, orig[i]); after_edge();
         check("gap_vld", {31'h0, bus.dout_valid}, 32'h1);
         ct[i] = bus.ctxt_char;
         drive(1'b0, 8'h00, 1'b0, 8'h00); after_edge();
         check("gap_idle", {31'h0, bus.dout_valid}, 32'h0);
      end
      drive(1'b1, 8'h41, 1'b0, 8'h00);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 8'h00, 1'b1, ct[i]); after_edge();
         check("decrypt", {24'h0, bus.ctxt_char}, {24'h0, orig[i]});
      end

      // key load colliding with a valid byte
      drive(1'b0, 8'h00, 1'b1, 8'h12);
      drive(1'b1, 8'h41, 1'b1, 8'h55); after_edge();
      check("collide_vld", {31'h0, bus.dout_valid}, 32'h0);
      drive(1'b0, 8'h00, 1'b1, 8'h41); after_edge();
      check("collide_next", {24'h0, bus.ctxt_char}, 32'hc2);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 31) == 0, 8'($urandom), $urandom_range(0, 3) != 0, 8'($urandom));

      // asynchronous reset mid-stream
      drive(1'b1, 8'h41, 1'b0, 8'h00);
      drive(1'b0, 8'h00, 1'b1, 8'h33);
      drive(1'b0, 8'h00, 1'b1, 8'h34);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctxt",  {24'h0, bus.ctxt_char},  32'h0);
      check("arst_valid", {31'h0, bus.dout_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.key_in = 1'b0; bus.din_valid = 1'b1; bus.ptxt_char = 8'h10;
      after_edge();
      check("post_rst_b0", {24'h0, bus.ctxt_char}, 32'h73);
      drive(1'b0, 8'h00, 1'b1, 8'h10); after_edge();
      check("post_rst_b1", {24'h0, bus.ctxt_char}, 32'h6c);

      drive(1'b0, 8'h00, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
